// File: rtl/sync_fifo_level_pkg.sv
// Shared constants and helpers for sync_fifo_level.
// Holds the default parameter values and the pointer/level width function.
// The default build has the read/write bypass disabled. Define SYNC_FIFO_LEVEL_BYPASS_EN
// to enable it.
package sync_fifo_level_pkg;

  localparam int unsigned DEF_WIDTH      = 8;
  localparam int unsigned DEF_DEPTH_LOG2 = 4;
  localparam int unsigned DEF_AF_THRESH  = 12;
  localparam int unsigned DEF_AE_THRESH  = 2;

  // Pointer/level width for a given entry count: one index bit per log2 step plus a wrap bit.
  function automatic int unsigned level_width(input int unsigned depth);
    return unsigned'($clog2(depth)) + 32'd1;
  endfunction

endpackage

// File: rtl/sync_fifo_level_mem.sv
// Storage array for sync_fifo_level.
// It has one synchronous write port and one asynchronous read port. There is no reset.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (combinational read).
module sync_fifo_level_mem
  import sync_fifo_level_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  localparam int unsigned DEPTH = 32'd1 << DEPTH_LOG2;

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Asynchronous read port.
  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_level.sv
// Synchronous show-ahead FIFO with a level output and threshold flags.
// Ports:
//   clk, rst_n (async active-low), clr (sync flush)
//   wr_en/din: push;  rd_en: pop;  dout: head of queue (0 when empty)
//   full, empty, almost_full, almost_empty, level: occupancy status
//   overflow, underflow: sticky error flags, cleared by clr or reset
// Optional: define SYNC_FIFO_LEVEL_BYPASS_EN so that a read and a write while empty
// pass din straight through to dout.
module sync_fifo_level
  import sync_fifo_level_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int unsigned AF_THRESH  = DEF_AF_THRESH,
  parameter int unsigned AE_THRESH  = DEF_AE_THRESH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      din,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned DEPTH = 32'd1 << DEPTH_LOG2;
  localparam int unsigned PTR_W = level_width(DEPTH);
  localparam int unsigned IDX_W = DEPTH_LOG2;

  logic [PTR_W-1:0] wptr, rptr;
  logic [WIDTH-1:0] rd_data;
  logic             bypass, push, pop, ovf_evt, unf_evt;

  // Status decoded from the registered pointers; the MSB is the wrap flag.
  assign empty        = (wptr == rptr);
  assign full         = (wptr[PTR_W-1] != rptr[PTR_W-1]) &&
                        (wptr[IDX_W-1:0] == rptr[IDX_W-1:0]);
  assign level        = wptr - rptr;
  assign almost_full  = (level >= PTR_W'(AF_THRESH));
  assign almost_empty = (level <= PTR_W'(AE_THRESH));

`ifdef SYNC_FIFO_LEVEL_BYPASS_EN
  // Reading and writing while empty forwards din without touching storage.
  assign bypass = empty & rd_en & wr_en;
`else
  assign bypass = 1'b0;
`endif

  // A read in the same cycle frees a slot, so a full FIFO still accepts the write.
  assign pop     = rd_en & ~empty;
  assign push    = wr_en & (~full | rd_en) & ~bypass;
  assign ovf_evt = wr_en & full & ~rd_en;
  assign unf_evt = rd_en & empty & ~bypass;

  // Pointer and sticky flag registers; clr wins over any transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      wptr      <= '0;
      rptr      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push)    wptr      <= wptr + PTR_W'(1);
      if (pop)     rptr      <= rptr + PTR_W'(1);
      if (ovf_evt) overflow  <= 1'b1;
      if (unf_evt) underflow <= 1'b1;
    end
  end

  sync_fifo_level_mem #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .clk   (clk),
    .we    (push & ~clr),
    .waddr (wptr[IDX_W-1:0]),
    .wdata (din),
    .raddr (rptr[IDX_W-1:0]),
    .rdata (rd_data)
  );

  // Show-ahead output: the head entry, the bypassed input, or zero.
  always_comb begin
    dout = '0;
    if (!empty)      dout = rd_data;
    else if (bypass) dout = din;
  end

endmodule

// File: tb/tb_sync_fifo_level.sv
// Directed testbench for sync_fifo_level with a queue scoreboard and immediate assertions.
module tb_sync_fifo_level;

  localparam int unsigned DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n, clr, wr_en, rd_en;
  logic [7:0] din, dout;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] level;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  logic       m_ovf, m_unf;

  sync_fifo_level dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .wr_en        (wr_en),
    .din          (din),
    .rd_en        (rd_en),
    .dout         (dout),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .level        (level),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every status output against the scoreboard model.
  task automatic check_state();
    int n;
    n = q.size();
    check("level",        64'(level),        64'(n));
    check("empty",        64'(empty),        64'(n == 0));
    check("full",         64'(full),         64'(n == DEPTH));
    check("almost_full",  64'(almost_full),  64'(n >= 12));
    check("almost_empty", 64'(almost_empty), 64'(n <= 2));
    check("overflow",     64'(overflow),     64'(m_ovf));
    check("underflow",    64'(underflow),    64'(m_unf));
    check("head_dout",    64'(dout),         (n == 0) ? 64'h0 : 64'(q[0]));
  endtask

  // One clock of stimulus. Read data is compared before the edge. Status is compared after it.
  task automatic step(input logic c, input logic w, input logic r, input logic [7:0] d);
    logic m_empty, m_full, byp;
    clr = c; wr_en = w; rd_en = r; din = d;
    #2;
    m_empty = (q.size() == 0);
    m_full  = (q.size() == DEPTH);
`ifdef SYNC_FIFO_LEVEL_BYPASS_EN
    byp = w && r && m_empty;
`else
    byp = 1'b0;
`endif
    if (c) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (byp) begin
      check("bypass_dout", 64'(dout), 64'(d));
    end else begin
      if (r && !m_empty) begin
        check("pop_dout", 64'(dout), 64'(q[0]));
        void'(q.pop_front());
      end
      if (w && (!m_full || r)) q.push_back(d);
      if (w && m_full && !r)   m_ovf = 1'b1;
      if (r && m_empty)        m_unf = 1'b1;
    end
    @(posedge clk);
    #1;
    clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = 8'h00;
    #1;
    check_state();
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = 8'h00;
    m_ovf = 1'b0; m_unf = 1'b0;
    #3;
    check_state();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #2;

    // Fill 0x01..0x10, then drain in order.
    for (int i = 1; i <= 16; i++) step(1'b0, 1'b1, 1'b0, 8'(i));
    for (int i = 0; i < 16; i++)  step(1'b0, 1'b0, 1'b1, 8'h00);

    // Refill. Write while full is dropped. A read and a write while full keeps the level.
    for (int i = 1; i <= 16; i++) step(1'b0, 1'b1, 1'b0, 8'(i));
    step(1'b0, 1'b1, 1'b0, 8'hAA);
    step(1'b0, 1'b1, 1'b1, 8'h55);
    for (int i = 0; i < 16; i++)  step(1'b0, 1'b0, 1'b1, 8'h00);

    // Read while empty. Then clr clears the sticky flags.
    step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);

    // Read and write while empty.
    step(1'b0, 1'b1, 1'b1, 8'h3C);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);

    // Pointer wrap-around with concurrent traffic.
    for (int i = 0; i < 3; i++)  step(1'b0, 1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b1, 8'($urandom));
    while (q.size() != 0)        step(1'b0, 1'b0, 1'b1, 8'h00);

    // clr at level 5.
    for (int i = 0; i < 5; i++)  step(1'b0, 1'b1, 1'b0, 8'(8'hA0 + i));
    step(1'b1, 1'b0, 1'b0, 8'h00);

    // Asynchronous reset between edges with data queued.
    for (int i = 0; i < 4; i++)  step(1'b0, 1'b1, 1'b0, 8'(8'hC0 + i));
    step(1'b0, 1'b1, 1'b0, 8'hEE);
    #1 rst_n = 1'b0;
    #1;
    q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    check_state();
    #2 rst_n = 1'b1;
    @(posedge clk);
    #2;
    step(1'b0, 1'b1, 1'b0, 8'h77);
    step(1'b0, 1'b1, 1'b0, 8'h78);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
